// File: rtl/mem_io_responder_if.sv
// CPU-side byte memory bus: address/command/write data from the CPU,
// registered read data and the TX near-full flag back to it.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a, mem_wr, mem_dout,
        input  mem_din, io_buffer_full
    );

    modport slave (
        input  mem_a, mem_wr, mem_dout,
        output mem_din, io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: on-chip RAM plus the 0x3xxxx I/O window
// (UART TX FIFO, UART RX pop, cycle counter with snapshot, program stop).
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    mem_io_responder_if.slave   bus,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                program_stop,
    output logic                tx_overflow
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(TX_DEPTH);
    localparam logic [CW-1:0] CNT_HIGH = CW'(TX_DEPTH - 2);

    logic [31:0]              counter_q;
    logic [31:0]              snap_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic [PW-1:0]            wr_ptr_q;
    logic [PW-1:0]            rd_ptr_q;
    logic                     tx_valid_q;
    logic                     full_q;
    logic                     stop_q;
    logic                     ovf_q;
    logic                     sel_ram_q;
    logic [7:0]               io_rd_q;
    logic [7:0]               io_rd_d;
    logic [7:0]               ram_rd_q;
    logic [7:0]               ram_q  [2**RAM_ADDR_WIDTH];
    logic [7:0]               fifo_q [TX_DEPTH];

    logic                     is_io;
    logic                     wr;
    logic [15:0]              io_off;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic                     uart_wr;
    logic                     stop_wr;
    logic                     push_req;
    logic [7:0]               push_byte;
    logic                     pop;
    logic                     push_en;
    logic                     overflow_evt;
    logic                     unused_addr_bits;

    assign is_io            = (bus.mem_a[17:16] == 2'b11);
    assign wr               = bus.mem_wr;
    assign io_off           = bus.mem_a[15:0];
    assign ram_addr         = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign unused_addr_bits = ^bus.mem_a[31:18];

    // A write to the stop address queues a literal 0x00, which the UART
    // data port would otherwise filter out.
    assign uart_wr      = is_io && wr && (io_off == 16'h0000) && (bus.mem_dout != 8'h00);
    assign stop_wr      = is_io && wr && (io_off == 16'h0004);
    assign push_req     = uart_wr || stop_wr;
    assign push_byte    = stop_wr ? 8'h00 : bus.mem_dout;
    assign pop          = tx_valid_q && tx_ready;
    assign push_en      = push_req && ((count_q != CNT_FULL) || pop);
    assign overflow_evt = push_req && (count_q == CNT_FULL) && !pop;

    assign rx_ready = rx_valid && is_io && !wr && (io_off == 16'h0000);

    always_comb begin
        io_rd_d = 8'h00;
        case (io_off)
            16'h0000: io_rd_d = rx_valid ? rx_data : 8'h00;
            16'h0004: io_rd_d = counter_q[7:0];
            16'h0005: io_rd_d = snap_q[15:8];
            16'h0006: io_rd_d = snap_q[23:16];
            16'h0007: io_rd_d = snap_q[31:24];
            default:  io_rd_d = 8'h00;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_en && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // RAM and FIFO storage carry no reset so they map onto plain memory.
    always_ff @(posedge clk_in) begin
        if (!is_io && wr) begin
            ram_q[ram_addr] <= bus.mem_dout;
        end
        if (!is_io && !wr) begin
            ram_rd_q <= ram_q[ram_addr];
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_en) begin
            fifo_q[wr_ptr_q] <= push_byte;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            counter_q  <= 32'd0;
            snap_q     <= 32'd0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_valid_q <= 1'b0;
            full_q     <= 1'b0;
            stop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            sel_ram_q  <= 1'b0;
            io_rd_q    <= 8'h00;
        end else begin
            counter_q <= counter_q + 32'd1;
            if (!wr) begin
                sel_ram_q <= !is_io;
                if (is_io) begin
                    io_rd_q <= io_rd_d;
                    if (io_off == 16'h0004) begin
                        snap_q <= counter_q;
                    end
                end
            end
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q    <= count_d;
            tx_valid_q <= (count_d != '0);
            full_q     <= (count_d >= CNT_HIGH);
            if (stop_wr) begin
                stop_q <= 1'b1;
            end
            if (overflow_evt) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Read data is held across writes: the mux selects whichever side
    // captured the most recent read.
    assign bus.mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
    assign bus.io_buffer_full = full_q;
    assign tx_data            = fifo_q[rd_ptr_q];
    assign tx_valid           = tx_valid_q;
    assign program_stop       = stop_q;
    assign tx_overflow        = ovf_q;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: a per-cycle vector table for the bus,
// FIFO and RX paths, then hand sequences for counter snapshot and reset.
module tb_mem_io_responder;
    localparam logic [31:0] IDLE = 32'h0003_0010;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       program_stop;
    logic       tx_overflow;

    mem_io_responder_if bus ();

    mem_io_responder #(.RAM_ADDR_WIDTH(17), .TX_DEPTH(8)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .bus          (bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .program_stop (program_stop),
        .tx_overflow  (tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic        e_rxr;
        logic [7:0]  e_din;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_full;
        logic        e_ovf;
        logic        e_stop;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   edge_cnt = 0;

    function automatic vec_t mk(input logic [31:0] a, input logic wr, input logic [7:0] dout,
                                input logic txr, input logic rxv, input logic [7:0] rxd,
                                input logic e_rxr, input logic [7:0] e_din, input logic e_txv,
                                input logic [7:0] e_txd, input logic e_full, input logic e_ovf,
                                input logic e_stop);
        vec_t v;
        v.a = a; v.wr = wr; v.dout = dout; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
        v.e_rxr = e_rxr; v.e_din = e_din; v.e_txv = e_txv; v.e_txd = e_txd;
        v.e_full = e_full; v.e_ovf = e_ovf; v.e_stop = e_stop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] dout,
                         input logic txr, input logic rxv, input logic [7:0] rxd);
        bus.mem_a    = a;
        bus.mem_wr   = wr;
        bus.mem_dout = dout;
        tx_ready     = txr;
        rx_valid     = rxv;
        rx_data      = rxd;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] dout);
        drive(a, wr, dout, 1'b0, 1'b0, 8'h00);
        tick();
        $display("cyc a=%h wr=%b dout=%h -> din=%h txv=%b txd=%h stop=%b ovf=%b",
                 a, wr, dout, bus.mem_din, tx_valid, tx_data, program_stop, tx_overflow);
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        logic [19:0] act;
        logic [19:0] exp;
        drive(v.a, v.wr, v.dout, v.txr, v.rxv, v.rxd);
        #1;
        chk($sformatf("vec%0d_rx_ready", idx), {31'd0, rx_ready}, {31'd0, v.e_rxr});
        @(posedge clk);
        edge_cnt++;
        #1;
        act = {bus.mem_din, tx_valid, (v.e_txv ? tx_data : 8'h00),
               bus.io_buffer_full, tx_overflow, program_stop};
        exp = {v.e_din, v.e_txv, (v.e_txv ? v.e_txd : 8'h00), v.e_full, v.e_ovf, v.e_stop};
        $display("vec %0d a=%h wr=%b dout=%h txr=%b -> din=%h txv=%b txd=%h full=%b ovf=%b stop=%b",
                 idx, v.a, v.wr, v.dout, v.txr, bus.mem_din, tx_valid, tx_data,
                 bus.io_buffer_full, tx_overflow, program_stop);
        chk($sformatf("vec%0d_{din,txv,txd,full,ovf,stop}", idx), {12'd0, act}, {12'd0, exp});
    endtask

    initial begin
        logic [31:0] snapv;
        logic [31:0] e2;

        // RAM write/read, hold on write, back-to-back reads
        vecs.push_back(mk(32'h0000_0123, 1, 8'hA5, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0124, 1, 8'h3C, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0123, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0124, 0, 8'h00, 0, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0055, 1, 8'h77, 0, 0, 8'h00, 0, 8'h3C, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0123, 0, 8'h00, 0, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0055, 0, 8'h00, 0, 0, 8'h00, 0, 8'h77, 0, 8'h00, 0, 0, 0));
        // TX path with zero filter, then drain
        vecs.push_back(mk(32'h0003_0000, 1, 8'h41, 0, 0, 8'h00, 0, 8'h77, 1, 8'h41, 0, 0, 0));
        vecs.push_back(mk(32'h0003_0000, 1, 8'h00, 0, 0, 8'h00, 0, 8'h77, 1, 8'h41, 0, 0, 0));
        vecs.push_back(mk(32'h0003_0000, 1, 8'h42, 0, 0, 8'h00, 0, 8'h77, 1, 8'h41, 0, 0, 0));
        vecs.push_back(mk(IDLE,          0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h42, 0, 0, 0));
        vecs.push_back(mk(IDLE,          0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(IDLE,          0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        // RX pop and its qualifiers
        vecs.push_back(mk(32'h0003_0000, 0, 8'h00, 0, 1, 8'h5A, 1, 8'h5A, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0003_0000, 0, 8'h00, 0, 0, 8'h5A, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0000_0123, 0, 8'h00, 0, 1, 8'h5A, 0, 8'hA5, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0003_0000, 1, 8'h00, 0, 1, 8'h5A, 0, 8'hA5, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(32'h0003_0001, 0, 8'h00, 0, 1, 8'h5A, 0, 8'h00, 0, 8'h00, 0, 0, 0));
        // Fill to 8: near-full rises at 6 entries
        for (int k = 1; k <= 8; k++) begin
            vecs.push_back(mk(32'h0003_0000, 1, 8'(k), 0, 0, 8'h00, 0, 8'h00, 1, 8'h01,
                              (k >= 6), 0, 0));
        end
        // Push+pop while full: no drop; then push while full: dropped
        vecs.push_back(mk(32'h0003_0000, 1, 8'h0A, 1, 0, 8'h00, 0, 8'h00, 1, 8'h02, 1, 0, 0));
        vecs.push_back(mk(32'h0003_0000, 1, 8'h09, 0, 0, 8'h00, 0, 8'h00, 1, 8'h02, 1, 1, 0));
        vecs.push_back(mk(IDLE, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h03, 1, 1, 0));
        vecs.push_back(mk(IDLE, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h04, 1, 1, 0));
        vecs.push_back(mk(IDLE, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h05, 0, 1, 0));
        vecs.push_back(mk(IDLE, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h06, 0, 1, 0));
        vecs.push_back(mk(IDLE, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h07, 0, 1, 0));
        vecs.push_back(mk(IDLE, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h08, 0, 1, 0));
        vecs.push_back(mk(IDLE, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 1, 8'h0A, 0, 1, 0));
        vecs.push_back(mk(IDLE, 0, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0));

        rst = 1'b1;
        drive(IDLE, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {24'd0, bus.mem_din, tx_valid, bus.io_buffer_full, program_stop, tx_overflow},
            32'd0);
        rst = 1'b0;
        edge_cnt = 0;

        foreach (vecs[i]) apply_vec(i, vecs[i]);

        // Counter snapshot coherence across a stall; run long enough for byte 1 to be nonzero
        repeat (400) tick();
        snapv = 32'(edge_cnt);
        cyc(32'h0003_0004, 1'b0, 8'h00);
        chk("cnt_byte0", {24'd0, bus.mem_din}, {24'd0, snapv[7:0]});
        repeat (10) cyc(IDLE, 1'b0, 8'h00);
        cyc(32'h0003_0005, 1'b0, 8'h00);
        chk("snap_byte1", {24'd0, bus.mem_din}, {24'd0, snapv[15:8]});
        cyc(32'h0003_0006, 1'b0, 8'h00);
        chk("snap_byte2", {24'd0, bus.mem_din}, {24'd0, snapv[23:16]});
        cyc(32'h0003_0007, 1'b0, 8'h00);
        chk("snap_byte3", {24'd0, bus.mem_din}, {24'd0, snapv[31:24]});
        e2 = 32'(edge_cnt);
        cyc(32'h0003_0004, 1'b0, 8'h00);
        chk("cnt_byte0_again", {24'd0, bus.mem_din}, {24'd0, e2[7:0]});

        // Program stop, then asynchronous reset mid-queue
        cyc(32'h0000_0123, 1'b0, 8'h00);
        chk("ram_before_stop", {24'd0, bus.mem_din}, 32'h0000_00A5);
        cyc(32'h0003_0004, 1'b1, 8'h99);
        chk("stop_write", {23'd0, bus.mem_din, tx_valid, program_stop}, {23'd0, 8'hA5, 1'b1, 1'b1});
        chk("stop_queued_zero", {24'd0, tx_data}, 32'd0);
        cyc(32'h0003_0000, 1'b1, 8'h33);
        chk("queue_after_stop", {30'd0, tx_valid, tx_overflow}, {30'd0, 1'b1, 1'b1});
        drive(32'h0000_0123, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset", {24'd0, bus.mem_din, tx_valid, bus.io_buffer_full, program_stop, tx_overflow},
            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        edge_cnt = 0;
        cyc(32'h0003_0005, 1'b0, 8'h00);
        chk("snap_after_reset", {24'd0, bus.mem_din}, 32'd0);
        cyc(32'h0003_0004, 1'b0, 8'h00);
        chk("cnt_after_reset", {24'd0, bus.mem_din}, 32'd1);
        chk("fifo_discarded", {31'd0, tx_valid}, 32'd0);
        cyc(32'h0000_0123, 1'b0, 8'h00);
        chk("ram_kept_123", {24'd0, bus.mem_din}, 32'h0000_00A5);
        cyc(32'h0000_0055, 1'b0, 8'h00);
        chk("ram_kept_55", {22'd0, bus.mem_din, program_stop, tx_overflow}, {22'd0, 8'h77, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
